mem_request_unit: RTL and testbench



---
 rtl/mem_request_unit_pkg.sv | 16 +
 rtl/mem_request_unit_mar.sv | 20 ++
 rtl/mem_request_unit.sv | 112 +++++++++++
 tb/tb_mem_request_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_request_unit_pkg.sv
// Shared definitions for the data-memory requester: bus width defaults, FSM encoding
// and the latency counter width.
package mem_request_unit_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 20;
  localparam int LAT_W      = 2;   // holds READ_LAT-1 for READ_LAT in 1..4

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_request_unit_mar.sv
// Memory address register: loads on accept, optional +1 step (wraps modulo 2^W).
// Load takes priority over increment.
module mem_request_unit_mar #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
    else if (inc)  q <= q + 1'b1;
  end

endmodule

// File: rtl/mem_request_unit.sv
// CPU-side data memory requester: one access per accepted request, no queuing, no response backpressure.
// Optional MEM_REQ_AUTOINC_EN: req_seq reuses MAR, and MAR steps by one after every completed access.
module mem_request_unit
  import mem_request_unit_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_REQ_AUTOINC_EN
  input  logic              req_seq,
`endif
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write,
  output logic              mem_wr_select,
  input  logic [DATA_W-1:0] mem_read
);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  mdr;
  logic               we_q;
  logic [LAT_W-1:0]   lat_cnt;
  logic               accept;
  logic               mar_load;
  logic               mar_inc;
  logic [ADDR_W-1:0]  mar;

  assign accept = req_valid & req_ready;

`ifdef MEM_REQ_AUTOINC_EN
  assign mar_load = accept & ~req_seq;
  assign mar_inc  = (state == ST_RESP);
`else
  assign mar_load = accept;
  assign mar_inc  = 1'b0;
`endif

  mem_request_unit_mar #(.W(ADDR_W)) u_mar (
    .clk   (clk),
    .reset (reset),
    .load  (mar_load),
    .inc   (mar_inc),
    .d     (req_addr),
    .q     (mar)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (lat_cnt == '0) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset removes them without waiting for a clock.
  always_comb begin
    req_ready     = 1'b0;
    busy          = 1'b1;
    mem_wr_select = 1'b0;
    resp_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_ACCESS: mem_wr_select = we_q;
      ST_RESP:   resp_valid    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdr        <= '0;
      we_q       <= 1'b0;
      lat_cnt    <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        we_q <= req_we;
        if (req_we) mdr <= req_wdata;
      end
      if (state == ST_ACCESS && !we_q) lat_cnt <= LAT_W'(READ_LAT - 1);
      if (state == ST_WAIT) begin
        if (lat_cnt != '0) lat_cnt    <= lat_cnt - 1'b1;
        else               resp_rdata <= mem_read;
      end
    end
  end

  assign mem_addr  = mar;
  assign mem_write = mdr;

endmodule

// File: tb/tb_mem_request_unit.sv
// Bench for mem_request_unit: two instances (READ_LAT=1 and READ_LAT=3), each with its own RAM model.
module tb_mem_request_unit;

  logic clk;
  logic reset;
  logic [1:0]       rv, rwe, rsq, rdy, rspv, bsy, wsel;
  logic [1:0][9:0]  ra, maddr;
  logic [1:0][19:0] rwd, rdat, mwr, mrd;

  int checks = 0;
  int errors = 0;

  mem_request_unit #(.ADDR_W(10), .DATA_W(20), .READ_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]),
`ifdef MEM_REQ_AUTOINC_EN
    .req_seq(rsq[0]),
`endif
    .resp_valid(rspv[0]), .resp_rdata(rdat[0]), .busy(bsy[0]), .mem_addr(maddr[0]),
    .mem_write(mwr[0]), .mem_wr_select(wsel[0]), .mem_read(mrd[0])
  );

  mem_request_unit #(.ADDR_W(10), .DATA_W(20), .READ_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]),
`ifdef MEM_REQ_AUTOINC_EN
    .req_seq(rsq[1]),
`endif
    .resp_valid(rspv[1]), .resp_rdata(rdat[1]), .busy(bsy[1]), .mem_addr(maddr[1]),
    .mem_write(mwr[1]), .mem_wr_select(wsel[1]), .mem_read(mrd[1])
  );

  // Passive RAMs: registered read, READ_LAT stages of pipeline
  logic [19:0]      mem0 [1024];
  logic [19:0]      mem1 [1024];
  logic [19:0]      p0;
  logic [2:0][19:0] p1;

  always @(posedge clk) begin
    if (wsel[0]) mem0[maddr[0]] <= mwr[0];
    if (wsel[1]) mem1[maddr[1]] <= mwr[1];
    p0 <= mem0[maddr[0]];
    p1 <= {p1[1:0], mem1[maddr[1]]};
  end
  assign mrd[0] = p0;
  assign mrd[1] = p1[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", n, d, act, exp);
    end
  endtask

  // Issue one request at the next falling edge and follow it to completion.
  task automatic run_req(input int d, input logic we, input logic [9:0] a, input logic [9:0] ea,
                         input logic [19:0] wd, input logic hold, input int lat,
                         input logic [19:0] er, input logic seq);
    int acc, nsel, got;
    @(negedge clk);
    chk("ready_idle", d, rdy[d], 1);
    rv[d] = 1'b1; rwe[d] = we; ra[d] = a; rwd[d] = wd; rsq[d] = seq;
    acc = 1; nsel = 0; got = 0;
    for (int c = 1; c <= 12 && got == 0; c++) begin
      @(negedge clk);
      if (rv[d] && rdy[d]) acc++;
      if (!hold) rv[d] = 1'b0;
      if (c == 1) begin
        chk("busy_access", d, bsy[d], 1);
        chk("sel_access", d, wsel[d], we);
        chk("mem_addr", d, maddr[d], ea);
        if (we) chk("mem_write", d, mwr[d], wd);
      end
      if (wsel[d]) nsel++;
      if (rspv[d]) begin
        got = c;
        chk("resp_rdata", d, rdat[d], er);
      end
    end
    rv[d] = 1'b0; rsq[d] = 1'b0;
    chk("latency", d, got, lat);
    chk("sel_count", d, nsel, we);
    chk("accepts", d, acc, 1);
    @(negedge clk);
    chk("pulse_end", d, rspv[d], 0);
    chk("idle_busy", d, bsy[d], 0);
    chk("rdata_held", d, rdat[d], er);
  endtask

  typedef struct {
    int          d;
    logic        we;
    logic [9:0]  a;
    logic [19:0] wd;
    logic        hold;
    int          lat;
    logic [19:0] er;
  } vec_t;

  vec_t vecs [8];
  int   seen;

  initial begin
    vecs[0] = '{0, 1'b1, 10'h005, 20'h0ABCD, 1'b0, 2, 20'h00000};
    vecs[1] = '{0, 1'b0, 10'h005, 20'h00000, 1'b0, 3, 20'h0ABCD};
    vecs[2] = '{0, 1'b1, 10'h3FF, 20'h12345, 1'b0, 2, 20'h0ABCD};
    vecs[3] = '{0, 1'b0, 10'h3FF, 20'h00000, 1'b0, 3, 20'h12345};
    vecs[4] = '{1, 1'b1, 10'h3FF, 20'hFFFFF, 1'b0, 2, 20'h00000};
    vecs[5] = '{1, 1'b0, 10'h3FF, 20'h00000, 1'b1, 5, 20'hFFFFF};
    vecs[6] = '{1, 1'b1, 10'h000, 20'h54321, 1'b0, 2, 20'hFFFFF};
    vecs[7] = '{1, 1'b0, 10'h000, 20'h00000, 1'b0, 5, 20'h54321};

    reset = 1'b1;
    rv = '0; rwe = '0; rsq = '0; ra = '0; rwd = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, rdy[d], 1);
      chk("rst_busy", d, bsy[d], 0);
      chk("rst_resp", d, rspv[d], 0);
      chk("rst_sel", d, wsel[d], 0);
      chk("rst_addr", d, maddr[d], 0);
      chk("rst_wdata", d, mwr[d], 0);
      chk("rst_rdata", d, rdat[d], 0);
    end
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_req(vecs[i].d, vecs[i].we, vecs[i].a, vecs[i].a, vecs[i].wd, vecs[i].hold,
              vecs[i].lat, vecs[i].er, 1'b0);

    // Back-to-back stores with req_valid held: second accepted only after IDLE
    @(negedge clk);
    rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 10'h010; rwd[0] = 20'h11111;
    @(negedge clk);
    chk("b2b_sel1", 0, wsel[0], 1);
    chk("b2b_addr1", 0, maddr[0], 10'h010);
    chk("b2b_wr1", 0, mwr[0], 20'h11111);
    ra[0] = 10'h011; rwd[0] = 20'h22222;
    @(negedge clk);
    chk("b2b_resp1", 0, rspv[0], 1);
    chk("b2b_rdy_resp", 0, rdy[0], 0);
    chk("b2b_rdata1", 0, rdat[0], 20'h12345);
    @(negedge clk);
    chk("b2b_idle_rdy", 0, rdy[0], 1);
    chk("b2b_idle_sel", 0, wsel[0], 0);
    @(negedge clk);
    rv[0] = 1'b0;
    chk("b2b_sel2", 0, wsel[0], 1);
    chk("b2b_addr2", 0, maddr[0], 10'h011);
    chk("b2b_wr2", 0, mwr[0], 20'h22222);
    @(negedge clk);
    chk("b2b_resp2", 0, rspv[0], 1);
    chk("b2b_rdata2", 0, rdat[0], 20'h12345);
    @(negedge clk);
    chk("b2b_done", 0, bsy[0], 0);
    run_req(0, 1'b0, 10'h011, 10'h011, 20'h0, 1'b0, 3, 20'h22222, 1'b0);
    run_req(0, 1'b0, 10'h010, 10'h010, 20'h0, 1'b0, 3, 20'h11111, 1'b0);

    // Reset while dut1 waits on a load and dut0 is in a store ACCESS
    @(negedge clk);
    rv[1] = 1'b1; rwe[1] = 1'b0; ra[1] = 10'h3FF;
    @(negedge clk);
    rv[1] = 1'b0;
    rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 10'h020; rwd[0] = 20'h0BEEF;
    @(negedge clk);
    rv[0] = 1'b0;
    chk("pre_rst_sel", 0, wsel[0], 1);
    chk("pre_rst_busy", 1, bsy[1], 1);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mid_rst_busy", d, bsy[d], 0);
      chk("mid_rst_sel", d, wsel[d], 0);
      chk("mid_rst_addr", d, maddr[d], 0);
      chk("mid_rst_ready", d, rdy[d], 1);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rspv != 2'b00) seen++;
    end
    chk("no_resp_after_rst", 0, seen, 0);
    run_req(1, 1'b0, 10'h3FF, 10'h3FF, 20'h0, 1'b0, 5, 20'hFFFFF, 1'b0);

`ifdef MEM_REQ_AUTOINC_EN
    run_req(0, 1'b1, 10'h000, 10'h000, 20'h0CAFE, 1'b0, 2, 20'h00000, 1'b0);
    run_req(0, 1'b1, 10'h3FE, 10'h3FE, 20'hAAAAA, 1'b0, 2, 20'h00000, 1'b0);
    run_req(0, 1'b1, 10'h123, 10'h3FF, 20'hBBBBB, 1'b0, 2, 20'h00000, 1'b1);
    run_req(0, 1'b0, 10'h155, 10'h000, 20'h0, 1'b0, 3, 20'h0CAFE, 1'b1);
    run_req(0, 1'b0, 10'h3FF, 10'h3FF, 20'h0, 1'b0, 3, 20'hBBBBB, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
